uart_tx_framer: RTL and testbench
=================================

UART_TX_FRAMER -- requirements
Module: uart_tx_framer

Interface
REQ-001 Parameter CLKS_PER_BIT, default 1085 (125000000/115200), clock cycles per bit period; legal range >= 2.
REQ-002 Parameter PARITY_EN, default 1, 1 = insert parity bit after the data bits, 0 = no parity bit.
REQ-003 Parameter PARITY_ODD, default 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN = 0.
REQ-004 clk  input  1  single clock for all logic.
REQ-005 rst  input  1  asynchronous reset, active-high.
REQ-006 start  input  1  transmit request, sampled on rising clk.
REQ-007 data  input  8  byte to send, sampled in the same cycle start is accepted.
REQ-008 tx  output  1  serial line, idle high.
REQ-009 busy  output  1  high while a frame is in progress.
REQ-010 done  output  1  one-cycle pulse when a frame completes.

Function
REQ-011 Frame format SHALL be: start bit (0), data[0]..data[7] LSB first, parity bit when PARITY_EN = 1, one stop bit (1).
REQ-012 Every bit SHALL be driven on tx for exactly CLKS_PER_BIT cycles, timed by a baud counter of width $clog2(CLKS_PER_BIT).
REQ-013 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP.
REQ-014 Transitions:
- IDLE->START on start = 1.
- START->DATA after CLKS_PER_BIT cycles.
- DATA->PARITY (PARITY_EN = 1) or DATA->STOP (PARITY_EN = 0) after the 8th bit period, counted by a 4-bit bit counter.
- PARITY->STOP after one bit period.
- STOP->IDLE after one bit period.
REQ-015 start SHALL be accepted only in IDLE; data SHALL be latched into an internal shift register on acceptance; start while busy = 1 SHALL be ignored; changes to data after acceptance SHALL not affect the frame.
REQ-016 Latency: if start is accepted at edge k, tx SHALL go low at edge k+1 and busy SHALL go high at edge k+1.
REQ-017 Parity bit SHALL be the XOR of the 8 latched data bits, inverted when PARITY_ODD = 1.
REQ-018 Frame length SHALL be F = (11 if PARITY_EN else 10) x CLKS_PER_BIT cycles; busy SHALL be high exactly for those F cycles.
REQ-019 done SHALL pulse for one cycle in the first IDLE cycle after STOP completes, coincident with busy falling.
REQ-020 start asserted in the cycle done is high SHALL be accepted, so back-to-back frames have no idle gap beyond that cycle.
REQ-021 tx SHALL be registered, glitch-free, and high in IDLE.
REQ-022 The bit counter and baud counter SHALL clear on entry to each state; wrap beyond terminal count SHALL not occur.

Reset
REQ-023 On rst = 1, asynchronously: state = IDLE, tx = 1, busy = 0, done = 0, counters = 0, shift register = 0.
REQ-024 rst asserted mid-frame SHALL abort the frame immediately, with no stop bit and no done pulse.
REQ-025 After rst deasserts, the first start in IDLE SHALL begin a fresh frame.

Verification (CLKS_PER_BIT = 4 unless noted)
REQ-026 data = 0x55, PARITY_EN = 1, even parity, start pulse at edge 0 -> tx holds each of 0,1,0,1,0,1,0,1,0,0,1 for 4 cycles from edge 1; busy high for 44 cycles; done at edge 45.
REQ-027 data = 0x01, PARITY_ODD = 1 -> parity bit = 0; with PARITY_EN = 0 -> frame is 40 cycles, tx pattern 0,1,0,0,0,0,0,0,0,1.
REQ-028 start held high continuously with data = 0xA3 then 0x3C -> two frames separated by exactly one IDLE cycle; done pulses once per frame; the data change during frame 1 does not affect frame 1.
REQ-029 rst asserted at cycle 20 of a frame -> tx = 1 and busy = 0 with no clock edge; done never pulses; the next start produces a correct full frame.
REQ-030 Default CLKS_PER_BIT = 1085, data = 0xFF -> each bit lasts exactly 1085 cycles (a receiver model at 115200 baud decodes 0xFF with even parity bit = 0).

Source files
------------

// File: rtl/uart_tx_framer.sv
// UART transmit framer: start bit, 8 data bits LSB first, optional parity, one stop bit.
// tx, busy and done are registered one cycle behind the FSM state, so all outputs are glitch-free.
module uart_tx_framer #(
    parameter int unsigned CLKS_PER_BIT = 1085,
    parameter int unsigned PARITY_EN    = 1,
    parameter int unsigned PARITY_ODD   = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int unsigned BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t        state, state_nxt;
    logic [BW-1:0] baud_cnt;
    logic [3:0]    bit_cnt;
    logic [7:0]    shift;
    logic          par;
    logic          fin;
    logic          baud_last;
    logic          bit_last;
    logic          accept;
    logic          tx_nxt;
    logic          frame_end;

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        tx_nxt    = 1'b1;
        baud_last = (baud_cnt == BAUD_LAST);
        bit_last  = (bit_cnt == 4'd7);
        frame_end = 1'b0;
        case (state)
            IDLE: begin
                tx_nxt = 1'b1;
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                tx_nxt = 1'b0;
                if (baud_last) state_nxt = DATA;
            end
            DATA: begin
                tx_nxt = shift[0];
                if (baud_last && bit_last) state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
            end
            PARITY: begin
                tx_nxt = par;
                if (baud_last) state_nxt = STOP;
            end
            STOP: begin
                tx_nxt = 1'b1;
                if (baud_last) begin
                    state_nxt = IDLE;
                    frame_end = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            tx       <= 1'b1;
            busy     <= 1'b0;
            fin      <= 1'b0;
            done     <= 1'b0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            par      <= 1'b0;
        end else begin
            state <= state_nxt;
            tx    <= tx_nxt;
            busy  <= (state != IDLE);
            // fin marks the STOP->IDLE edge; done follows it so it lines up with busy falling
            fin   <= frame_end;
            done  <= fin;

            if (state_nxt != state) begin
                baud_cnt <= '0;
                bit_cnt  <= '0;
            end else if (baud_last) begin
                baud_cnt <= '0;
                if (state == DATA) bit_cnt <= bit_cnt + 4'd1;
            end else begin
                baud_cnt <= baud_cnt + BW'(1);
            end

            if (accept) begin
                shift <= data;
                par   <= (^data) ^ (PARITY_ODD != 0);
            end else if (state == DATA && baud_last) begin
                shift <= {1'b0, shift[7:1]};
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed bench for uart_tx_framer: several parameter sets, hand-computed frame patterns.
module tb_uart_tx_framer;

    logic       clk;
    logic       rst;
    logic [7:0] data;
    logic       start_a, start_b, start_c, start_d;
    logic       tx_a, tx_b, tx_c, tx_d;
    logic       busy_a, busy_b, busy_c, busy_d;
    logic       done_a, done_b, done_c, done_d;

    int n_assert = 0;
    int n_fail   = 0;

    uart_tx_framer #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .data(data), .tx(tx_a), .busy(busy_a), .done(done_a));
    uart_tx_framer #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .data(data), .tx(tx_b), .busy(busy_b), .done(done_b));
    uart_tx_framer #(.CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0)) dut_c (
        .clk(clk), .rst(rst), .start(start_c), .data(data), .tx(tx_c), .busy(busy_c), .done(done_c));
    uart_tx_framer dut_d (
        .clk(clk), .rst(rst), .start(start_d), .data(data), .tx(tx_d), .busy(busy_d), .done(done_d));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic pick_tx(input int sel);
        case (sel)
            0: return tx_a;
            1: return tx_b;
            2: return tx_c;
            default: return tx_d;
        endcase
    endfunction

    function automatic logic pick_busy(input int sel);
        case (sel)
            0: return busy_a;
            1: return busy_b;
            2: return busy_c;
            default: return busy_d;
        endcase
    endfunction

    function automatic logic pick_done(input int sel);
        case (sel)
            0: return done_a;
            1: return done_b;
            2: return done_c;
            default: return done_d;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input int sel, input string tag);
        chk({tag, " tx"}, pick_tx(sel), 1'b1);
        chk({tag, " busy"}, pick_busy(sel), 1'b0);
        chk({tag, " done"}, pick_done(sel), 1'b0);
    endtask

    // Called right after the accepting edge (edge 0); pat[i] is the i-th bit on the line.
    // Returns just after the edge where done must pulse.
    task automatic run_frame(input int sel, input int nbits, input logic [10:0] pat,
                             input int cpb, input string tag);
        for (int b = 0; b < nbits; b++) begin
            for (int c = 0; c < cpb; c++) begin
                tick();
                chk({tag, " tx"}, pick_tx(sel), pat[b]);
                chk({tag, " busy"}, pick_busy(sel), 1'b1);
                chk({tag, " done"}, pick_done(sel), 1'b0);
            end
        end
        tick();
        chk({tag, " end done"}, pick_done(sel), 1'b1);
        chk({tag, " end busy"}, pick_busy(sel), 1'b0);
        chk({tag, " end tx"}, pick_tx(sel), 1'b1);
    endtask

    initial begin
        rst = 1'b0;
        data = 8'h00;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0; start_d = 1'b0;
        #1 rst = 1'b1;
        #1;
        for (int s = 0; s < 4; s++) chk_idle(s, "reset");
        tick();
        rst = 1'b0;
        tick();
        chk_idle(0, "post reset");

        // 0x55 even parity: 0,1,0,1,0,1,0,1,0,0,1
        data = 8'h55; start_a = 1'b1;
        tick();
        start_a = 1'b0; data = 8'hFF;
        run_frame(0, 11, 11'b10010101010, 4, "a55");
        tick();
        chk_idle(0, "a55 after");

        // 0x01 odd parity: parity bit 0
        data = 8'h01; start_b = 1'b1;
        tick();
        start_b = 1'b0;
        run_frame(1, 11, 11'b10000000010, 4, "b01odd");
        tick();
        chk_idle(1, "b01 after");

        // 0x01 no parity: 10-bit frame
        start_c = 1'b1;
        tick();
        start_c = 1'b0;
        run_frame(2, 10, 11'b01000000010, 4, "c01nopar");
        tick();
        chk_idle(2, "c01 after");

        // start held high: 0xA3 then 0x3C, one idle cycle between frames
        data = 8'hA3; start_a = 1'b1;
        tick();
        data = 8'h3C;
        run_frame(0, 11, 11'b10101000110, 4, "bb1 A3");
        start_a = 1'b0;
        run_frame(0, 11, 11'b10001111000, 4, "bb2 3C");
        tick();
        chk_idle(0, "bb after");

        // reset 20 cycles into a frame
        data = 8'h55; start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (20) tick();
        chk("pre-abort busy", busy_a, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk_idle(0, "abort async");
        tick();
        chk_idle(0, "abort held");
        rst = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            chk("abort no done", done_a, 1'b0);
        end
        chk_idle(0, "abort idle");
        data = 8'h3C; start_a = 1'b1;
        tick();
        start_a = 1'b0;
        run_frame(0, 11, 11'b10001111000, 4, "after abort 3C");

        // default baud: 0xFF, even parity bit 0, 1085 cycles per bit
        tick();
        data = 8'hFF; start_d = 1'b1;
        tick();
        start_d = 1'b0;
        run_frame(3, 11, 11'b10111111110, 1085, "dFF");
        tick();
        chk_idle(3, "dFF after");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
